nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer that computes wide 2's-complement sums on one shared 4-bit ripple slice, one nibble per clock.
//  Slice = four structuralFullAdder cells with carry-in and carry-into-MSB exposed.
//  Controller latches operands, steps the nibble index, chains the carry through a register and assembles the result.
//  Sits between a requesting datapath and the adder hardware; trades latency for area.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices per operand; operand width W = 4*NIBBLES (>=2)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   request; sampled only when ready=1
//  a         in   W   operand A, 2's complement; sampled on accepting edge
//  b         in   W   operand B, 2's complement; sampled on accepting edge
//  ready     out  1   1 = IDLE, request can be accepted
//  busy      out  1   1 = RUN, ~ready
//  done      out  1   one-cycle pulse: sum/carryout/overflow valid
//  sum       out  W   result, held until next accepted start
//  carryout  out  1   carry out of MSB of final nibble
//  overflow  out  1   signed overflow of W-bit result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, sum=0, carryout=0, overflow=0, idx=0, carry reg=0.
//  FSM IDLE -> RUN on edge E0 with start=1: latch a,b; idx=0; carry reg=0; sum cleared to 0; carryout/overflow cleared.
//  RUN, edges E1..EN (N=NIBBLES): slice adds a[4i+:4], b[4i+:4], carry reg.
//    sum[4i+:4] <= slice sum; carry reg <= slice cout; idx <= idx+1.
//  On EN (idx==N-1): carryout <= slice cout; overflow <= slice cout XOR carry-into-MSB.
//    Also done <= 1 and state -> IDLE.
//  done high exactly one cycle after EN, cleared on next edge. ready=1 in that same cycle.
//  Latency start-accept to done = N edges. Back-to-back: start during done cycle accepted at next edge.
//  start while busy: ignored, no queueing; latched operands and in-flight result unaffected.
//  a/b changes during RUN: ignored (latched copies used).
//  idx never wraps past N-1. Carry chaining is unsigned mod 2^W; overflow per 2's-complement rule.
//  sum nibbles below idx are final; upper nibbles read 0 until written. Consumers sample only on done.
//  Reset mid-RUN: immediate abort to reset values; partial result discarded; no done pulse.
//  Timing: slice is gate-level (#50 per gate). Clock period must exceed worst ripple (>=500 units; bench uses 1000).
// CONFIGURATION
//  SERIAL_SUB_EN defined: adds port `sub in 1`, sampled with start.
//    sub=1: latched b is inverted and carry reg initialised to 1 (A-B).
//    carryout=1 means no borrow; overflow per same MSB-carry XOR rule. sub=0: plain add.
//  SERIAL_SUB_EN undefined: no sub port; add only; carry reg initialised to 0.
// TESTING  (NIBBLES=4, W=16, clk period 1000)
//  a=0x0005,b=0x000A,start 1 cycle -> done 4 edges after accept, sum=0x000F, carryout=0, overflow=0.
//  a=0xFFFF,b=0x0001 -> sum=0x0000, carryout=1, overflow=0 (carry ripples through all nibbles).
//  a=0x7FFF,b=0x0001 -> sum=0x8000, carryout=0, overflow=1; a=0x8000,b=0x8000 -> 0x0000, cout=1, ovf=1.
//  Accept 0x1234+0x1111; pulse start with 0xFFFF+0xFFFF at E2 -> ignored, done shows 0x2345, ready=0 E1..EN.
//  Assert reset after E2 of an add -> outputs 0 at once, ready=1, no done; next start 0x0001+0x0001 -> 0x0002.
//  SERIAL_SUB_EN: 0x0003-0x0005 -> 0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Computes wide 2's-complement sums one nibble per clock on a single shared
// 4-bit ripple slice. The operands are latched when the request is accepted.
// The carry is chained between nibbles through a register, and the result is
// assembled in place.
// Optional feature: define SERIAL_SUB_EN to add a 'sub' input that selects A-B.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         carryout,
  output logic         overflow
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  state_t         next_state;
  logic           accept;
  logic           last_step;
  logic           sub_sel;
  logic [W-1:0]   a_lat;
  logic [W-1:0]   b_lat;
  logic [IW-1:0]  idx;
  logic           carry_reg;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     slice_sum;
  logic [4:0]     slice_c;

`ifdef SERIAL_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  // The slice only ever sees the nibble that is selected by the current step index
  assign a_nib = a_lat[{idx, 2'b00} +: 4];
  assign b_nib = b_lat[{idx, 2'b00} +: 4];

  // Four full-adder cells rippling from the registered carry; slice_c[3] is the carry into the MSB
  assign slice_c[0] = carry_reg;
  for (genvar k = 0; k < 4; k++) begin : g_fa
    assign slice_sum[k]   = a_nib[k] ^ b_nib[k] ^ slice_c[k];
    assign slice_c[k+1]   = (a_nib[k] & b_nib[k]) | (slice_c[k] & (a_nib[k] ^ b_nib[k]));
  end

  // State register; reset aborts any in-flight operation immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: accept only in IDLE, return to IDLE after the final nibble
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          last_step  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then write one sum nibble per step and chain the carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat     <= '0;
      b_lat     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_lat     <= a;
        b_lat     <= sub_sel ? ~b : b;
        idx       <= '0;
        carry_reg <= sub_sel;
        sum       <= '0;
        carryout  <= 1'b0;
        overflow  <= 1'b0;
      end else if (state == RUN) begin
        sum[{idx, 2'b00} +: 4] <= slice_sum;
        carry_reg              <= slice_c[4];
        if (last_step) begin
          carryout <= slice_c[4];
          overflow <= slice_c[4] ^ slice_c[3];
          done     <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Directed and random requests to nibble_serial_adder_ctrl (NIBBLES=4). The
// results are compared against an arithmetic reference model.
// Define SERIAL_SUB_EN on both files to exercise subtraction.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int vectors;
  int miscompares;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SERIAL_SUB_EN
    .sub      (sub),
`endif
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  // 1000-unit clock period
  initial clk = 1'b0;
  always #500 clk = ~clk;

  // One comparison: count it, and report a failure if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed and unsigned interpretation of the wide operation
  task automatic refModel(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output logic [W-1:0] es, output logic ec, output logic eo);
    int sa, sb, sr;
    int ua, ub, ur;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    if (sv) begin
      sr = sa - sb;
      ur = ua - ub;
      ec = (ua >= ub);
    end else begin
      sr = sa + sb;
      ur = ua + ub;
      ec = (ur >= 65536);
    end
    es = W'(ur);
    eo = (sr > 32767) || (sr < -32768);
  endtask

  // Present a request on a falling edge and return one cycle after it is accepted
  task automatic startOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    checkOutput("ready_before_start", 32'(ready), 32'd1);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("ready_after_accept", 32'(ready), 32'd0);
    checkOutput("done_clear_after_accept", 32'(done), 32'd0);
  endtask

  // Wait on done with a bounded number of cycles
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full transaction: start, wait for done, compare against the model. Returns in the done cycle.
  task automatic applyStimulus(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic sv);
    logic [W-1:0] es;
    logic ec, eo;
    int cyc;
    refModel(av, bv, sv, es, ec, eo);
    startOp(av, bv, sv);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(N));
    checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
    checkOutput({tag, "_cout"}, 32'(carryout), 32'(ec));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(eo));
    checkOutput({tag, "_ready_in_done"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int seen_done;
    logic [W-1:0] ra, rb;
    logic rs;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(carryout), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed additions
    applyStimulus("add_5_a", 16'h0005, 16'h000A, 1'b0);
    checkOutput("add_5_a_sum_const", 32'(sum), 32'h000F);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    applyStimulus("ripple_all", 16'hFFFF, 16'h0001, 1'b0);
    checkOutput("ripple_all_const", 32'({carryout, sum}), 32'h10000);
    // Back-to-back: the next request is presented during the done cycle
    applyStimulus("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    checkOutput("pos_ovf_const", 32'({overflow, carryout, sum}), 32'h28000);
    applyStimulus("neg_ovf", 16'h8000, 16'h8000, 1'b0);
    checkOutput("neg_ovf_const", 32'({overflow, carryout, sum}), 32'h30000);
    @(negedge clk);

    // Start while busy is ignored
    startOp(16'h1234, 16'h1111, 1'b0);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    checkOutput("ignore_ready_e1", 32'(ready), 32'd0);
    start = 1'b0;
    waitDone(cyc);
    checkOutput("ignore_latency", 32'(cyc + 1), 32'(N));
    checkOutput("ignore_sum", 32'(sum), 32'h2345);
    checkOutput("ignore_cout", 32'(carryout), 32'd0);
    @(negedge clk);
    checkOutput("ignore_no_requeue", 32'(busy), 32'd0);

    // Reset mid-run aborts without a done pulse
    startOp(16'hABCD, 16'h1357, 1'b0);
    @(negedge clk);
    #100;
    reset = 1'b1;
    #1;
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_flags", 32'({carryout, overflow}), 32'd0);
    #100;
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    applyStimulus("after_abort", 16'h0001, 16'h0001, 1'b0);
    checkOutput("after_abort_const", 32'(sum), 32'h0002);
    @(negedge clk);

`ifdef SERIAL_SUB_EN
    applyStimulus("sub_neg", 16'h0003, 16'h0005, 1'b1);
    checkOutput("sub_neg_const", 32'({overflow, carryout, sum}), 32'h0FFFE);
    applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    checkOutput("sub_ovf_const", 32'({overflow, carryout, sum}), 32'h37FFF);
    @(negedge clk);
`endif

    // Random requests, some back-to-back
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      applyStimulus("rand", ra, rb, rs);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
